// File: rtl/user_mgr_wrr_arbiter_if.sv
// OBI bundle between the user managers and the single shared manager port.
// The arbiter takes the slave view; the environment (managers plus bus) takes the master view.
interface user_mgr_wrr_arbiter_if #(
    parameter int unsigned NumMgr    = 2,
    parameter int unsigned AddrWidth = 32,
    parameter int unsigned DataWidth = 32
);
    localparam int unsigned BeWidth = DataWidth / 8;

    // Per-manager side
    logic [NumMgr-1:0]           sbr_req;
    logic [NumMgr-1:0]           sbr_gnt;
    logic [NumMgr*AddrWidth-1:0] sbr_addr;
    logic [NumMgr-1:0]           sbr_we;
    logic [NumMgr*BeWidth-1:0]   sbr_be;
    logic [NumMgr*DataWidth-1:0] sbr_wdata;
    logic [NumMgr-1:0]           sbr_rvalid;
    logic [DataWidth-1:0]        sbr_rdata;
    logic                        sbr_err;

    // Shared manager port
    logic                        mgr_req;
    logic                        mgr_gnt;
    logic [AddrWidth-1:0]        mgr_addr;
    logic                        mgr_we;
    logic [BeWidth-1:0]          mgr_be;
    logic [DataWidth-1:0]        mgr_wdata;
    logic                        mgr_rvalid;
    logic [DataWidth-1:0]        mgr_rdata;
    logic                        mgr_err;

    modport slave (
        input  sbr_req, sbr_addr, sbr_we, sbr_be, sbr_wdata,
        input  mgr_gnt, mgr_rvalid, mgr_rdata, mgr_err,
        output sbr_gnt, sbr_rvalid, sbr_rdata, sbr_err,
        output mgr_req, mgr_addr, mgr_we, mgr_be, mgr_wdata
    );

    modport master (
        output sbr_req, sbr_addr, sbr_we, sbr_be, sbr_wdata,
        output mgr_gnt, mgr_rvalid, mgr_rdata, mgr_err,
        input  sbr_gnt, sbr_rvalid, sbr_rdata, sbr_err,
        input  mgr_req, mgr_addr, mgr_we, mgr_be, mgr_wdata
    );
endinterface

// File: rtl/user_mgr_wrr_arbiter.sv
// Weighted round-robin arbiter sharing one OBI manager port between NumMgr user managers.
// Manager i may take weight[i]+1 consecutive grants per turn; responses return in issue order
// using a FIFO of issuer indices.
module user_mgr_wrr_arbiter #(
    parameter int unsigned NumMgr      = 2,
    parameter int unsigned AddrWidth   = 32,
    parameter int unsigned DataWidth   = 32,
    parameter int unsigned NumMaxTrans = 2,
    parameter int unsigned WeightWidth = 4
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic [NumMgr*WeightWidth-1:0] weights_i,
    user_mgr_wrr_arbiter_if.slave         bus,
    output logic                          busy_o,
    output logic                          spurious_rsp_o
);
    localparam int unsigned BeWidth = DataWidth / 8;
    localparam int unsigned IdxW    = $clog2(NumMgr);
    localparam int unsigned PtrW    = (NumMaxTrans > 1) ? $clog2(NumMaxTrans) : 1;
    localparam int unsigned CntW    = $clog2(NumMaxTrans + 1);
    localparam int unsigned UsedW   = WeightWidth + 1;
    localparam logic [UsedW-1:0] UsedMax = {1'b1, {WeightWidth{1'b0}}};

    typedef logic [IdxW-1:0] idx_t;
    typedef logic [PtrW-1:0] ptr_t;

    // Per-manager views of the flat buses
    logic [WeightWidth-1:0] weight [NumMgr];
    logic [AddrWidth-1:0]   addr   [NumMgr];
    logic [BeWidth-1:0]     be     [NumMgr];
    logic [DataWidth-1:0]   wdata  [NumMgr];

    // Arbitration state
    idx_t             owner_q, owner_d;
    logic [UsedW-1:0] used_q, used_d;
    logic             lock_q, lock_d;
    idx_t             lock_sel_q, lock_sel_d;

    // In-order issuer FIFO
    idx_t            id_mem_q [NumMaxTrans];
    ptr_t            wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0] count_q, count_d;

    idx_t              sel, cand, head;
    logic              found, owner_credit, slot_free, hs, pop;
    logic [NumMgr-1:0] gnt_vec, rvalid_vec;

    function automatic ptr_t ptr_inc(ptr_t p);
        return (p == ptr_t'(NumMaxTrans - 1)) ? '0 : p + ptr_t'(1);
    endfunction

    // Unpack the flat per-manager buses
    always_comb begin
        for (int unsigned i = 0; i < NumMgr; i++) begin
            weight[i] = weights_i[i*WeightWidth +: WeightWidth];
            addr[i]   = bus.sbr_addr[i*AddrWidth +: AddrWidth];
            be[i]     = bus.sbr_be[i*BeWidth +: BeWidth];
            wdata[i]  = bus.sbr_wdata[i*DataWidth +: DataWidth];
        end
    end

    assign owner_credit = (used_q <= {1'b0, weight[owner_q]});
    assign slot_free    = (count_q < CntW'(NumMaxTrans));
    assign hs           = bus.sbr_req[sel] && slot_free && bus.mgr_gnt;
    assign pop          = bus.mgr_rvalid && (count_q != '0);
    assign head         = id_mem_q[rd_ptr_q];

    // Pick the manager: locked choice, else owner with credit left, else next requester cyclically
    always_comb begin
        sel   = owner_q;
        cand  = owner_q;
        found = 1'b0;
        if (lock_q) begin
            sel = lock_sel_q;
        end else if (bus.sbr_req[owner_q] && owner_credit) begin
            sel = owner_q;
        end else begin
            for (int unsigned k = 1; k <= NumMgr; k++) begin
                cand = idx_t'((32'(owner_q) + k) % NumMgr);
                if (!found && bus.sbr_req[cand]) begin
                    sel   = cand;
                    found = 1'b1;
                end
            end
        end
    end

    // Mux the A channel from sel and steer gnt/rvalid to single managers
    always_comb begin
        gnt_vec          = '0;
        gnt_vec[sel]     = hs;
        rvalid_vec       = '0;
        rvalid_vec[head] = pop;

        bus.mgr_req    = bus.sbr_req[sel] && slot_free;
        bus.mgr_addr   = addr[sel];
        bus.mgr_we     = bus.sbr_we[sel];
        bus.mgr_be     = be[sel];
        bus.mgr_wdata  = wdata[sel];
        bus.sbr_gnt    = gnt_vec;
        bus.sbr_rvalid = rvalid_vec;
        bus.sbr_rdata  = bus.mgr_rdata;
        bus.sbr_err    = bus.mgr_err;
        busy_o         = (count_q != '0);
        spurious_rsp_o = bus.mgr_rvalid && (count_q == '0);
    end

    // Next state for credits, lock and occupancy
    always_comb begin
        owner_d = owner_q;
        used_d  = used_q;
        if (hs) begin
            if ((sel == owner_q) && owner_credit) begin
                used_d = (used_q == UsedMax) ? used_q : used_q + UsedW'(1);
            end else begin
                owner_d = sel;
                used_d  = UsedW'(1);
            end
        end
        // Holds the choice while its request waits; a retracted request releases it too,
        // so a misbehaving manager cannot wedge the port.
        lock_d     = bus.sbr_req[sel] && !hs;
        lock_sel_d = lock_d ? sel : lock_sel_q;
        count_d    = count_q + CntW'(hs) - CntW'(pop);
    end

    // Arbitration registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            owner_q    <= '0;
            used_q     <= '0;
            lock_q     <= 1'b0;
            lock_sel_q <= '0;
            count_q    <= '0;
        end else begin
            owner_q    <= owner_d;
            used_q     <= used_d;
            lock_q     <= lock_d;
            lock_sel_q <= lock_sel_d;
            count_q    <= count_d;
        end
    end

    // Issuer FIFO storage and pointers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int unsigned i = 0; i < NumMaxTrans; i++) begin
                id_mem_q[i] <= '0;
            end
        end else begin
            if (hs) begin
                id_mem_q[wr_ptr_q] <= sel;
                wr_ptr_q           <= ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
        end
    end
endmodule

// File: tb/tb_user_mgr_wrr_arbiter.sv
// Bench for user_mgr_wrr_arbiter: directed scenarios followed by random OBI-compliant traffic,
// all compared against a queue-based reference model of the arbitration rules.
module tb_user_mgr_wrr_arbiter;
    localparam int unsigned N  = 2;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned BW = DW / 8;
    localparam int unsigned MT = 2;
    localparam int unsigned WW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [N*WW-1:0] weights = '0;
    logic          busy;
    logic          spurious;

    user_mgr_wrr_arbiter_if #(.NumMgr(N), .AddrWidth(AW), .DataWidth(DW)) bus ();

    user_mgr_wrr_arbiter #(
        .NumMgr(N), .AddrWidth(AW), .DataWidth(DW), .NumMaxTrans(MT), .WeightWidth(WW)
    ) dut (
        .clk_i(clk),
        .rst_ni(rst_n),
        .weights_i(weights),
        .bus(bus),
        .busy_o(busy),
        .spurious_rsp_o(spurious)
    );

    always #5 clk = ~clk;

    // Stimulus
    logic [N-1:0]  req_v;
    logic [AW-1:0] addr_v  [N];
    logic [N-1:0]  we_v;
    logic [BW-1:0] be_v    [N];
    logic [DW-1:0] wdata_v [N];
    logic          gnt_v, rvalid_v, err_v;
    logic [DW-1:0] rdata_v;

    // Reference model
    int m_owner, m_used, m_lock_sel;
    bit m_locked;
    int q[$];
    bit last_hs;

    // Observations of the last cycle
    logic [N-1:0]  last_gnt, last_rvalid;
    logic          last_req, last_spur;
    logic [AW-1:0] last_addr;
    logic [DW-1:0] last_rdata;

    int tests = 0;
    int fails = 0;
    int g;
    int order[8];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int weight_of(input int i);
        return int'(weights[i*WW +: WW]);
    endfunction

    function automatic int model_sel();
        if (m_locked) return m_lock_sel;
        if (req_v[m_owner] && m_used <= weight_of(m_owner)) return m_owner;
        for (int k = 1; k <= N; k++) begin
            int c = (m_owner + k) % N;
            if (req_v[c]) return c;
        end
        return m_owner;
    endfunction

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            bus.sbr_addr[i*AW +: AW]  = addr_v[i];
            bus.sbr_be[i*BW +: BW]    = be_v[i];
            bus.sbr_wdata[i*DW +: DW] = wdata_v[i];
        end
        bus.sbr_req    = req_v;
        bus.sbr_we     = we_v;
        bus.mgr_gnt    = gnt_v;
        bus.mgr_rvalid = rvalid_v;
        bus.mgr_rdata  = rdata_v;
        bus.mgr_err    = err_v;
    endtask

    task automatic clear_inputs();
        req_v = '0; we_v = '0; gnt_v = 0; rvalid_v = 0; err_v = 0; rdata_v = '0;
        for (int i = 0; i < N; i++) begin
            addr_v[i] = '0; be_v[i] = '0; wdata_v[i] = '0;
        end
    endtask

    // One clock: apply inputs, compare all outputs with the model, advance the model.
    task automatic cycle(output int granted);
        int sel;
        bit hs, pop, room;
        logic [N-1:0] eg, er;
        drive();
        #1;
        sel  = model_sel();
        room = q.size() < MT;
        hs   = req_v[sel] && room && gnt_v;
        pop  = rvalid_v && q.size() > 0;
        eg = '0; if (hs) eg[sel] = 1'b1;
        er = '0; if (pop) er[q[0]] = 1'b1;

        last_gnt = bus.sbr_gnt; last_rvalid = bus.sbr_rvalid; last_req = bus.mgr_req;
        last_spur = spurious; last_addr = bus.mgr_addr; last_rdata = bus.sbr_rdata;

        check("mgr_req", bus.mgr_req, req_v[sel] && room);
        check("sbr_gnt", bus.sbr_gnt, eg);
        check("sbr_rvalid", bus.sbr_rvalid, er);
        check("spurious", spurious, rvalid_v && q.size() == 0);
        check("busy", busy, q.size() != 0);
        check("mgr_addr", bus.mgr_addr, addr_v[sel]);
        check("mgr_we", bus.mgr_we, we_v[sel]);
        check("mgr_be", bus.mgr_be, be_v[sel]);
        check("mgr_wdata", bus.mgr_wdata, wdata_v[sel]);
        check("sbr_rdata", bus.sbr_rdata, rdata_v);
        check("sbr_err", bus.sbr_err, err_v);

        if (pop) void'(q.pop_front());
        if (hs) begin
            q.push_back(sel);
            if (sel == m_owner && m_used <= weight_of(m_owner)) begin
                m_used = (m_used + 1 > (1 << WW)) ? (1 << WW) : m_used + 1;
            end else begin
                m_owner = sel;
                m_used  = 1;
            end
        end
        m_locked   = req_v[sel] && !hs;
        m_lock_sel = sel;
        last_hs    = hs;
        granted    = hs ? sel : -1;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        clear_inputs();
        drive();
        rst_n = 1'b0;
        #1;
        check("rst_busy", busy, 0);
        check("rst_mgr_req", bus.mgr_req, 0);
        check("rst_sbr_gnt", bus.sbr_gnt, 0);
        check("rst_sbr_rvalid", bus.sbr_rvalid, 0);
        check("rst_spurious", spurious, 0);
        check("rst_mgr_addr", bus.mgr_addr, 0);
        check("rst_sbr_rdata", bus.sbr_rdata, 0);
        m_owner = 0; m_used = 0; m_locked = 0; m_lock_sel = 0; q.delete(); last_hs = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        // Reset and first handshake from manager 0
        do_reset();
        weights = '0;
        req_v = 2'b01; addr_v[0] = 32'h0000_1000; gnt_v = 1;
        cycle(g);
        check("t1_gnt", last_gnt, 2'b01);
        check("t1_grantee", g, 0);
        req_v = '0;
        cycle(g);
        check("t1_busy", busy, 1);
        rvalid_v = 1;
        cycle(g);
        check("t1_rvalid", last_rvalid, 2'b01);
        rvalid_v = 0;
        cycle(g);

        // Weighted order w0=2, w1=0
        do_reset();
        weights = {WW'(0), WW'(2)};
        req_v = 2'b11; gnt_v = 1;
        addr_v[0] = 32'hA000_0000; addr_v[1] = 32'hB000_0000;
        for (int i = 0; i < 8; i++) begin
            rvalid_v = last_hs; rdata_v = $urandom;
            cycle(order[i]);
        end
        for (int i = 0; i < 8; i++) begin
            check("t2_order", order[i], (i % 4 == 3) ? 1 : 0);
        end
        req_v = '0; rvalid_v = 1;
        cycle(g);
        rvalid_v = 0;

        // Gnt stall keeps selection and address stable
        do_reset();
        weights = {WW'(0), WW'(1)};
        req_v = 2'b01; addr_v[0] = 32'h0000_0100; gnt_v = 0;
        cycle(g);
        check("t3_stall_addr0", last_addr, 32'h100);
        req_v = 2'b11; addr_v[1] = 32'h0000_0200;
        cycle(g);
        check("t3_stall_addr1", last_addr, 32'h100);
        cycle(g);
        check("t3_stall_addr2", last_addr, 32'h100);
        gnt_v = 1;
        cycle(g);
        check("t3_first", g, 0);
        rvalid_v = last_hs;
        cycle(g);
        check("t3_second", g, 0);
        rvalid_v = last_hs;
        cycle(g);
        check("t3_third", g, 1);
        req_v = '0; rvalid_v = 1;
        cycle(g);
        rvalid_v = 0;

        // Outstanding limit
        do_reset();
        weights = '0;
        req_v = 2'b01; gnt_v = 1;
        cycle(g);
        cycle(g);
        cycle(g);
        check("t4_full_req", last_req, 0);
        check("t4_full_busy", busy, 1);
        rvalid_v = 1;
        cycle(g);
        check("t4_pop_route", last_rvalid, 2'b01);
        check("t4_pop_no_free", last_req, 0);
        rvalid_v = 0;
        cycle(g);
        check("t4_reassert", last_req, 1);
        check("t4_regrant", g, 0);
        req_v = '0; rvalid_v = 1;
        cycle(g);
        cycle(g);
        rvalid_v = 0;

        // In-order response routing with data
        do_reset();
        gnt_v = 1;
        req_v = 2'b10;
        cycle(g);
        check("t5_g1", g, 1);
        req_v = 2'b01;
        cycle(g);
        check("t5_g0", g, 0);
        req_v = '0; rvalid_v = 1; rdata_v = 32'hA5A5_0001;
        cycle(g);
        check("t5_rv1", last_rvalid, 2'b10);
        check("t5_rd1", last_rdata, 32'hA5A5_0001);
        rdata_v = 32'hA5A5_0002;
        cycle(g);
        check("t5_rv2", last_rvalid, 2'b01);
        check("t5_rd2", last_rdata, 32'hA5A5_0002);
        rvalid_v = 0; rdata_v = '0;
        cycle(g);

        // Lone manager with zero weight, then a spurious response
        do_reset();
        weights = '0;
        req_v = 2'b10; gnt_v = 1;
        for (int i = 0; i < 4; i++) begin
            rvalid_v = last_hs;
            cycle(g);
            check("t6_grant", g, 1);
        end
        req_v = '0; rvalid_v = 1;
        cycle(g);
        cycle(g);
        check("t6_spurious", last_spur, 1);
        check("t6_spur_rvalid", last_rvalid, 0);
        rvalid_v = 0;
        cycle(g);
        check("t6_spur_pulse", last_spur, 0);

        // Reset with a transaction in flight
        do_reset();
        req_v = 2'b01; gnt_v = 1;
        cycle(g);
        check("t7_busy", busy, 1);
        do_reset();
        rvalid_v = 1;
        cycle(g);
        check("t7_late_rsp", last_spur, 1);
        rvalid_v = 0;
        cycle(g);

        // Random OBI-compliant traffic
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            if (c % 64 == 0) weights = N*WW'($urandom);
            for (int i = 0; i < N; i++) begin
                if (!(req_v[i] && g != i)) begin
                    req_v[i]   = ($urandom % 3) != 0;
                    addr_v[i]  = $urandom;
                    we_v[i]    = $urandom % 2;
                    be_v[i]    = BW'($urandom);
                    wdata_v[i] = $urandom;
                end
            end
            gnt_v    = ($urandom % 4) != 0;
            rvalid_v = (q.size() > 0) ? ($urandom % 2 == 1) : ($urandom % 16 == 0);
            rdata_v  = $urandom;
            err_v    = $urandom % 2;
            cycle(g);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
